// File: rtl/stream_pkg.sv
// Shared stream definitions: default lane geometry and the keep-mask helper
// used by the byte packer and the wide datapath that consumes its words.
package stream_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_LANES  = 4;

    // Widest keep mask the helper can produce; callers slice their own width.
    localparam int MAX_LANES  = 64;

    // n contiguous ones starting at bit 0 (n = 0 gives an empty mask).
    function automatic logic [MAX_LANES-1:0] keep_mask(input int unsigned n);
        logic [MAX_LANES-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_LANES; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/stream_byte_packer.sv
// Byte-to-word packer: collects accepted bytes LSB-first into LANES-byte
// words and presents them on a valid/ready interface. A byte flagged last
// closes the word early with a partial keep mask. The accumulating word and
// the presented word share one register set; a new byte may be accepted only
// when no word is pending or the pending word is consumed in the same cycle.
module stream_byte_packer
    import stream_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LANES  = DEF_LANES
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_valid_i,
    input  logic [DATA_W-1:0]        i_data_i,
    input  logic                     i_last_i,
    output logic                     i_ready_o,
    input  logic                     e_ready_i,
    output logic                     e_valid_o,
    output logic [DATA_W*LANES-1:0]  e_data_o,
    output logic [LANES-1:0]         e_keep_o,
    output logic                     e_last_o
);

    localparam int CNT_W  = $clog2(LANES);
    localparam int WORD_W = DATA_W * LANES;

    logic [CNT_W-1:0]     r_cnt;
    logic [WORD_W-1:0]    r_data;
    logic [LANES-1:0]     r_keep;
    logic                 r_last;
    logic                 r_valid;

    logic [CNT_W-1:0]     w_cnt_n;
    logic [WORD_W-1:0]    w_data_n;
    logic [LANES-1:0]     w_keep_n;
    logic                 w_last_n;
    logic                 w_valid_n;
    logic [MAX_LANES-1:0] w_mask;
    logic                 w_acc;
    logic                 w_cons;

    assign i_ready_o = !r_valid || e_ready_i;
    assign w_acc     = i_valid_i && i_ready_o;
    assign w_cons    = r_valid && e_ready_i;

    assign e_valid_o = r_valid;
    assign e_data_o  = r_data;
    assign e_keep_o  = r_keep;
    assign e_last_o  = r_last;

    // Next-state: drop a consumed word, then merge an accepted byte into lane[cnt].
    always_comb begin
        w_cnt_n   = r_cnt;
        w_data_n  = r_data;
        w_keep_n  = r_keep;
        w_last_n  = r_last;
        w_valid_n = r_valid;
        w_mask    = keep_mask(32'(r_cnt) + 32'd1);

        if (w_cons) begin
            w_valid_n = 1'b0;
            w_data_n  = '0;
            w_keep_n  = '0;
            w_last_n  = 1'b0;
        end

        if (w_acc) begin
            for (int k = 0; k < LANES; k++) begin
                if (r_cnt == CNT_W'(k)) w_data_n[k*DATA_W +: DATA_W] = i_data_i;
            end
            // Keep is contiguous from lane 0, so lanes 0..cnt are all valid.
            w_keep_n = w_mask[LANES-1:0];
            if (r_cnt == CNT_W'(LANES-1) || i_last_i) begin
                w_valid_n = 1'b1;
                w_last_n  = i_last_i;
                w_cnt_n   = '0;
            end else begin
                w_cnt_n   = r_cnt + CNT_W'(1);
            end
        end
    end

    // State registers; asynchronous reset discards any partial or pending word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_data  <= '0;
            r_keep  <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_n;
            r_data  <= w_data_n;
            r_keep  <= w_keep_n;
            r_last  <= w_last_n;
            r_valid <= w_valid_n;
        end
    end

endmodule

// File: tb/tb_stream_byte_packer.sv
// Bench for stream_byte_packer: table of cycle vectors, hand-written
// reset/back-pressure sequences, and a randomized run against a
// queue-based packing model.
module tb_stream_byte_packer;

    localparam int DATA_W = 8;
    localparam int LANES  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid_i;
    logic [7:0]  i_data_i;
    logic        i_last_i;
    logic        i_ready_o;
    logic        e_ready_i;
    logic        e_valid_o;
    logic [31:0] e_data_o;
    logic [3:0]  e_keep_o;
    logic        e_last_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_byte_packer #(.DATA_W(DATA_W), .LANES(LANES)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_valid_i (i_valid_i),
        .i_data_i  (i_data_i),
        .i_last_i  (i_last_i),
        .i_ready_o (i_ready_o),
        .e_ready_i (e_ready_i),
        .e_valid_o (e_valid_o),
        .e_data_o  (e_data_o),
        .e_keep_o  (e_keep_o),
        .e_last_o  (e_last_o)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        l;
        logic        er;
        logic        x_ir;
        logic        x_ev;
        logic        chk;
        logic [31:0] x_ed;
        logic [3:0]  x_ek;
        logic        x_el;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic v, input logic [7:0] d, input logic l, input logic er,
                                input logic x_ir, input logic x_ev, input logic chk,
                                input logic [31:0] x_ed, input logic [3:0] x_ek, input logic x_el);
        vec_t r;
        r.v = v; r.d = d; r.l = l; r.er = er;
        r.x_ir = x_ir; r.x_ev = x_ev; r.chk = chk;
        r.x_ed = x_ed; r.x_ek = x_ek; r.x_el = x_el;
        tbl.push_back(r);
    endfunction

    // Drive one cycle: inputs at negedge, ready checked before the edge,
    // registered outputs checked 1 time unit after the edge.
    task automatic apply(input vec_t r, input string tag);
        @(negedge clk);
        i_valid_i = r.v; i_data_i = r.d; i_last_i = r.l; e_ready_i = r.er;
        #1;
        check({tag, "_ready"}, i_ready_o, r.x_ir);
        @(posedge clk);
        #1;
        check({tag, "_valid"}, e_valid_o, r.x_ev);
        if (r.chk) begin
            check({tag, "_data"}, e_data_o, r.x_ed);
            check({tag, "_keep"}, e_keep_o, r.x_ek);
            check({tag, "_last"}, e_last_o, r.x_el);
        end
    endtask

    task automatic cyc(input logic v, input logic [7:0] d, input logic l, input logic er,
                       input logic x_ir, input logic x_ev, input logic chk,
                       input logic [31:0] x_ed, input logic [3:0] x_ek, input logic x_el,
                       input string tag);
        vec_t r;
        r.v = v; r.d = d; r.l = l; r.er = er;
        r.x_ir = x_ir; r.x_ev = x_ev; r.chk = chk;
        r.x_ed = x_ed; r.x_ek = x_ek; r.x_el = x_el;
        apply(r, tag);
    endtask

    // Reference model state for the randomized phase.
    typedef struct { logic [31:0] data; logic [3:0] keep; logic last; } word_t;
    logic [7:0] part[$];
    word_t      wq[$];

    initial begin
        reset = 1'b1; i_valid_i = 1'b0; i_data_i = '0; i_last_i = 1'b0; e_ready_i = 1'b0;
        #1;
        check("reset_valid", e_valid_o, 1'b0);
        check("reset_data",  e_data_o, 32'h0);
        check("reset_keep",  e_keep_o, 4'h0);
        check("reset_last",  e_last_o, 1'b0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // v  d     l  er  ir ev chk data          keep  last
        // Streaming 0x01..0x08
        add(1, 8'h01, 0, 1, 1, 0, 0, 32'h0,        4'h0, 0);
        add(1, 8'h02, 0, 1, 1, 0, 0, 32'h0,        4'h0, 0);
        add(1, 8'h03, 0, 1, 1, 0, 0, 32'h0,        4'h0, 0);
        add(1, 8'h04, 0, 1, 1, 1, 1, 32'h04030201, 4'hF, 0);
        add(1, 8'h05, 0, 1, 1, 0, 0, 32'h0,        4'h0, 0);
        add(1, 8'h06, 0, 1, 1, 0, 0, 32'h0,        4'h0, 0);
        add(1, 8'h07, 0, 1, 1, 0, 0, 32'h0,        4'h0, 0);
        add(1, 8'h08, 0, 1, 1, 1, 1, 32'h08070605, 4'hF, 0);
        // Consume without accept clears the word
        add(0, 8'h00, 0, 1, 1, 0, 1, 32'h0,        4'h0, 0);
        // Partial flush, then 0xCC must start at lane 0
        add(1, 8'hAA, 0, 1, 1, 0, 0, 32'h0,        4'h0, 0);
        add(1, 8'hBB, 1, 1, 1, 1, 1, 32'h0000BBAA, 4'h3, 1);
        add(1, 8'hCC, 0, 1, 1, 0, 0, 32'h0,        4'h0, 0);
        add(1, 8'hDD, 0, 1, 1, 0, 0, 32'h0,        4'h0, 0);
        add(1, 8'hEE, 0, 1, 1, 0, 0, 32'h0,        4'h0, 0);
        add(1, 8'hFF, 0, 1, 1, 1, 1, 32'hFFEEDDCC, 4'hF, 0);
        add(0, 8'h00, 0, 1, 1, 0, 1, 32'h0,        4'h0, 0);
        // Single-byte packet, then a stalled byte that must not be taken
        add(1, 8'h5A, 1, 0, 1, 1, 1, 32'h0000005A, 4'h1, 1);
        add(1, 8'h77, 0, 0, 0, 1, 1, 32'h0000005A, 4'h1, 1);
        add(0, 8'h00, 0, 1, 1, 0, 1, 32'h0,        4'h0, 0);
        // Last byte in lane 3
        add(1, 8'h10, 0, 0, 1, 0, 0, 32'h0,        4'h0, 0);
        add(1, 8'h11, 0, 0, 1, 0, 0, 32'h0,        4'h0, 0);
        add(1, 8'h12, 0, 0, 1, 0, 0, 32'h0,        4'h0, 0);
        add(1, 8'h13, 1, 0, 1, 1, 1, 32'h13121110, 4'hF, 1);
        add(0, 8'h00, 0, 1, 1, 0, 1, 32'h0,        4'h0, 0);

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Reset in the middle of a word
        cyc(1, 8'h11, 0, 1, 1, 0, 0, 32'h0, 4'h0, 0, "rmw_b0");
        cyc(1, 8'h22, 0, 1, 1, 0, 0, 32'h0, 4'h0, 0, "rmw_b1");
        @(negedge clk);
        i_valid_i = 1'b0; reset = 1'b1;
        #1;
        check("rmw_async_valid", e_valid_o, 1'b0);
        check("rmw_async_data",  e_data_o, 32'h0);
        check("rmw_async_keep",  e_keep_o, 4'h0);
        @(negedge clk);
        reset = 1'b0;
        cyc(1, 8'hA0, 0, 1, 1, 0, 0, 32'h0, 4'h0, 0, "rmw_a0");
        cyc(1, 8'hA1, 0, 1, 1, 0, 0, 32'h0, 4'h0, 0, "rmw_a1");
        cyc(1, 8'hA2, 0, 1, 1, 0, 0, 32'h0, 4'h0, 0, "rmw_a2");
        cyc(1, 8'hA3, 0, 1, 1, 1, 1, 32'hA3A2A1A0, 4'hF, 0, "rmw_a3");

        // Back-pressure on the pending full word for 5 cycles
        for (int i = 0; i < 5; i++)
            cyc(1, 8'h99, 1, 0, 0, 1, 1, 32'hA3A2A1A0, 4'hF, 0, $sformatf("bp_stall%0d", i));
        cyc(1, 8'h99, 1, 1, 1, 1, 1, 32'h00000099, 4'h1, 1, "bp_release");
        cyc(0, 8'h00, 0, 1, 1, 0, 1, 32'h0, 4'h0, 0, "bp_drain");

        // Randomized run against the packing model
        @(negedge clk);
        reset = 1'b1; i_valid_i = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        part.delete();
        wq.delete();
        for (int n = 0; n < 3000; n++) begin
            logic v, l, er, acc, cons, mvalid;
            logic [7:0] d;
            @(negedge clk);
            v  = ($urandom_range(0, 3) != 0);
            d  = 8'($urandom);
            l  = ($urandom_range(0, 4) == 0);
            er = ($urandom_range(0, 3) != 0);
            i_valid_i = v; i_data_i = d; i_last_i = l; e_ready_i = er;
            #1;
            mvalid = (wq.size() != 0);
            check("rnd_ready", i_ready_o, !mvalid || er);
            acc  = v && (!mvalid || er);
            cons = mvalid && er;
            @(posedge clk);
            #1;
            if (cons) void'(wq.pop_front());
            if (acc) begin
                part.push_back(d);
                if (part.size() == LANES || l) begin
                    word_t w;
                    w.data = '0;
                    for (int k = 0; k < part.size(); k++) w.data |= 32'(part[k]) << (8 * k);
                    w.keep = 4'((1 << part.size()) - 1);
                    w.last = l;
                    wq.push_back(w);
                    part.delete();
                end
            end
            check("rnd_valid", e_valid_o, wq.size() != 0);
            if (wq.size() != 0) begin
                check("rnd_data", e_data_o, wq[0].data);
                check("rnd_keep", e_keep_o, wq[0].keep);
                check("rnd_last", e_last_o, wq[0].last);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
